// File: rtl/m_mul_iter.sv
// Iterative 32x32 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU,
// built around a single 64-bit carry-select adder shared by the accumulate and negate steps.

module m_adder (
  input  logic [63:0] i_op1_64,
  input  logic [63:0] i_op2_64,
  input  logic        i_cIn_1,
  output logic [63:0] o_sum_64,
  output logic        o_cOut_1
);

  logic [4:0] carry;

  assign carry[0] = i_cIn_1;

  // Each 16-bit block precomputes both carry-in outcomes; the incoming carry only selects.
  for (genvar g = 0; g < 4; g++) begin : gBlock
    logic [16:0] sum0;
    logic [16:0] sum1;

    assign sum0 = {1'b0, i_op1_64[g*16 +: 16]} + {1'b0, i_op2_64[g*16 +: 16]};
    assign sum1 = {1'b0, i_op1_64[g*16 +: 16]} + {1'b0, i_op2_64[g*16 +: 16]} + 17'd1;
    assign o_sum_64[g*16 +: 16] = carry[g] ? sum1[15:0] : sum0[15:0];
    assign carry[g+1]           = carry[g] ? sum1[16]   : sum0[16];
  end

  assign o_cOut_1 = carry[4];

endmodule

module m_mul_iter (
  input  logic        i_clk_1,
  input  logic        i_rst_1,
  input  logic        i_valid_1,
  input  logic [1:0]  i_mulOp_2,
  input  logic [31:0] i_rs1_32,
  input  logic [31:0] i_rs2_32,
  input  logic        i_flush_1,
  output logic        o_ready_1,
  output logic        o_valid_1,
  output logic [31:0] o_result_32
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  state_t      state;
  state_t      stateNext;

  logic [63:0] accP;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [4:0]  cnt;
  logic        neg;
  logic [1:0]  opReg;
  logic [31:0] result;

  logic        readyInt;
  logic        accept;
  logic        rs1Neg;
  logic        rs2Neg;
  logic [31:0] rs1Mag;
  logic [31:0] rs2Mag;

  logic [63:0] addOp1;
  logic [63:0] addOp2;
  logic        addCin;
  logic [63:0] addSum;
  logic        addCarryUnused;
  logic [63:0] finalP;

  assign readyInt    = (state == IDLE) || (state == DONE);
  assign o_ready_1   = readyInt;
  assign o_valid_1   = (state == DONE);
  assign o_result_32 = result;
  assign accept      = i_valid_1 && readyInt && !i_flush_1;

  // MUL and MULHU treat both operands as unsigned, so neg is 0 for them.
  assign rs1Neg = ((i_mulOp_2 == OP_MULH) || (i_mulOp_2 == OP_MULHSU)) && i_rs1_32[31];
  assign rs2Neg = (i_mulOp_2 == OP_MULH) && i_rs2_32[31];
  assign rs1Mag = rs1Neg ? (~i_rs1_32 + 32'd1) : i_rs1_32;
  assign rs2Mag = rs2Neg ? (~i_rs2_32 + 32'd1) : i_rs2_32;

  always_comb begin
    addOp1 = accP;
    addOp2 = '0;
    addCin = 1'b0;
    if (state == FIX) begin
      addOp1 = ~accP;
      addCin = 1'b1;
    end else if (mplier[0]) begin
      addOp2 = mcand;
    end
  end

  m_adder uAdder (
    .i_op1_64 (addOp1),
    .i_op2_64 (addOp2),
    .i_cIn_1  (addCin),
    .o_sum_64 (addSum),
    .o_cOut_1 (addCarryUnused)
  );

  assign finalP = neg ? addSum : accP;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) stateNext = BUSY;
      BUSY: if (cnt == 5'd31) stateNext = FIX;
      FIX:  stateNext = DONE;
      DONE: stateNext = accept ? BUSY : IDLE;
      default: stateNext = IDLE;
    endcase
    if (i_flush_1) begin
      stateNext = IDLE;
    end
  end

  always_ff @(posedge i_clk_1 or posedge i_rst_1) begin
    if (i_rst_1) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge i_clk_1 or posedge i_rst_1) begin
    if (i_rst_1) begin
      accP   <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      opReg  <= '0;
      result <= '0;
    end else if (accept) begin
      accP   <= '0;
      mcand  <= {32'b0, rs1Mag};
      mplier <= rs2Mag;
      cnt    <= '0;
      neg    <= rs1Neg ^ rs2Neg;
      opReg  <= i_mulOp_2;
    end else if (state == BUSY) begin
      accP   <= addSum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 5'd1;
    end else if ((state == FIX) && !i_flush_1) begin
      accP   <= finalP;
      result <= (opReg == OP_MUL) ? finalP[31:0] : finalP[63:32];
    end
  end

endmodule

// File: tb/tb_m_mul_iter.sv
// Directed bench for m_mul_iter: results, 34-cycle latency, back-to-back, flush and async reset.

module tb_m_mul_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        ready;
  logic        oValid;
  logic [31:0] result;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] lastRes;
  logic        sawValid;

  m_mul_iter dut (
    .i_clk_1     (clk),
    .i_rst_1     (rst),
    .i_valid_1   (valid),
    .i_mulOp_2   (op),
    .i_rs1_32    (rs1),
    .i_rs2_32    (rs2),
    .i_flush_1   (flush),
    .o_ready_1   (ready),
    .o_valid_1   (oValid),
    .o_result_32 (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in a cycle where ready is expected high; returns in the DONE cycle (cycle 34).
  task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int pulseAt);
    op    = o;
    rs1   = a;
    rs2   = b;
    valid = 1'b1;
    chk({tag, " readyAtAccept"}, {31'b0, ready}, 32'd1);
    step();
    for (int c = 1; c <= 33; c++) begin
      chk({tag, " busyReady"}, {31'b0, ready}, 32'd0);
      chk({tag, " busyValid"}, {31'b0, oValid}, 32'd0);
      chk({tag, " heldResult"}, result, lastRes);
      valid = (c == pulseAt);
      if (c == pulseAt) begin
        op  = 2'b11;
        rs1 = 32'h0000DEAD;
        rs2 = 32'h0000BEEF;
      end
      step();
    end
    valid = 1'b0;
    chk({tag, " doneValid"}, {31'b0, oValid}, 32'd1);
    chk({tag, " doneReady"}, {31'b0, ready}, 32'd1);
    chk({tag, " result"}, result, exp);
    lastRes = exp;
  endtask

  initial begin
    rst     = 1'b1;
    valid   = 1'b0;
    flush   = 1'b0;
    op      = 2'b00;
    rs1     = '0;
    rs2     = '0;
    lastRes = '0;

    #12;
    chk("resetReady", {31'b0, ready}, 32'd1);
    chk("resetValid", {31'b0, oValid}, 32'd0);
    chk("resetResult", result, 32'd0);
    rst = 1'b0;
    step();

    // Latency with an ignored request at cycle 5, then back-to-back accept in DONE.
    runOp("mul3x5", 2'b00, 32'h00000003, 32'h00000005, 32'h0000000F, 5);
    runOp("mulhNeg6", 2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 0);
    step();
    chk("idleAfterDoneValid", {31'b0, oValid}, 32'd0);
    chk("idleAfterDoneReady", {31'b0, ready}, 32'd1);

    runOp("mulhuMax", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    step();
    runOp("mulMax", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0);
    step();
    runOp("mulhMinMin", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 0);
    step();
    runOp("mulhNeg1x1", 2'b01, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 0);
    step();
    runOp("mulhsuNeg1", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    step();
    runOp("mulhsuMin", 2'b10, 32'h80000000, 32'h80000000, 32'hC0000000, 0);
    step();
    runOp("mulLowWrap", 2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 0);
    step();
    runOp("mulhZeroNeg", 2'b01, 32'h00000000, 32'h80000000, 32'h00000000, 0);
    step();
    runOp("mulhMaxPos", 2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 0);
    step();
    runOp("mulhuCarryOut", 2'b11, 32'h80000000, 32'h00000002, 32'h00000001, 0);
    step();

    // Flush at cycle 10 aborts the op.
    op    = 2'b00;
    rs1   = 32'h00000007;
    rs2   = 32'h00000009;
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int c = 1; c < 10; c++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flushReady", {31'b0, ready}, 32'd1);
    chk("flushValid", {31'b0, oValid}, 32'd0);
    sawValid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      sawValid = sawValid | oValid;
      step();
    end
    chk("flushNoValid", {31'b0, sawValid}, 32'd0);
    chk("flushResultHeld", result, lastRes);

    // Flush together with a request in IDLE: no accept.
    flush = 1'b1;
    valid = 1'b1;
    step();
    flush = 1'b0;
    valid = 1'b0;
    chk("flushIdleReady", {31'b0, ready}, 32'd1);
    sawValid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      sawValid = sawValid | oValid;
      step();
    end
    chk("flushIdleNoValid", {31'b0, sawValid}, 32'd0);

    // Async reset mid-BUSY at cycle 20.
    op    = 2'b11;
    rs1   = 32'h00001234;
    rs2   = 32'h00005678;
    valid = 1'b1;
    step();
    valid = 1'b0;
    for (int c = 1; c < 20; c++) step();
    chk("preResetBusy", {31'b0, ready}, 32'd0);
    #3 rst = 1'b1;
    #1;
    chk("asyncRstReady", {31'b0, ready}, 32'd1);
    chk("asyncRstValid", {31'b0, oValid}, 32'd0);
    chk("asyncRstResult", result, 32'd0);
    #1 rst = 1'b0;
    lastRes = '0;
    step();
    runOp("mulhuAfterRst", 2'b11, 32'h00010000, 32'h00010000, 32'h00000001, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
